trigger_debounce: RTL and testbench

Upstream trigger conditioner for the pulse-stretch counter. Takes a raw, asynchronous, bouncy external input and synchronizes it. It debounces the input with a consecutive-sample counter and emits a one-cycle `trig_out` pulse on qualified edges; `trig_out` drives the stretcher's `en`. It also exports the debounced level and a saturating event count for status readback.

---
 rtl/trigger_debounce.sv | 128 ++++++++++++
 tb/tb_trigger_debounce.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_debounce.sv
// rtl/trigger_debounce.sv - synchronizer, debounce FSM, edge-qualified trigger and event counter
// Turns a raw bouncy input into a clean level, a one-cycle trigger and a saturating press count.
module trigger_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             btn_in,
  input  logic [1:0]       mode,
  input  logic             evt_clr,
  output logic             level_out,
  output logic             trig_out,
  output logic [EVT_W-1:0] event_cnt
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE_LO,
    CHK_HI,
    IDLE_HI,
    CHK_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   trig_q;
  logic [EVT_W-1:0]       evt_q;
  logic                   qual_rise;
  logic                   qual_fall;
  logic                   trig_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The final stable sample of a check run is the edge that flips the level.
  assign qual_rise = (state_q == CHK_HI) && s && (cnt_q == CNT_LAST);
  assign qual_fall = (state_q == CHK_LO) && !s && (cnt_q == CNT_LAST);
  assign trig_d    = (qual_rise && mode[0]) || (qual_fall && mode[1]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      trig_q <= trig_d;
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_q <= CHK_HI;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HI;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_q <= CHK_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_LO: begin
          if (s) begin
            state_q <= IDLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LO;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Clear wins over a same-edge trigger, so that trigger is never counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_q <= '0;
    end else if (evt_clr) begin
      evt_q <= '0;
    end else if (trig_d && (evt_q != EVT_MAX)) begin
      evt_q <= evt_q + 1'b1;
    end
  end

  assign level_out = level_q;
  assign trig_out  = trig_q;
  assign event_cnt = evt_q;

endmodule

// File: tb/tb_trigger_debounce.sv
// tb/tb_trigger_debounce.sv - self-checking bench for trigger_debounce
// Reference model: delayed sample stream plus a run-length count of samples disagreeing with the level.
module tb_trigger_debounce;

  localparam int SS    = 2;
  localparam int DB    = 16;
  localparam int EW    = 3;
  localparam int EDGE  = SS + DB - 1;
  localparam int CMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          btn_in;
  logic [1:0]    mode;
  logic          evt_clr;
  logic          level_out;
  logic          trig_out;
  logic [EW-1:0] event_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trigger_debounce #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .EVT_W          (EW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .btn_in   (btn_in),
    .mode     (mode),
    .evt_clr  (evt_clr),
    .level_out(level_out),
    .trig_out (trig_out),
    .event_cnt(event_cnt)
  );

  bit m_sync[SS];
  bit m_level;
  bit m_trig;
  bit m_s;
  int m_streak;
  int m_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      foreach (m_sync[i]) m_sync[i] = 1'b0;
      m_level  = 1'b0;
      m_trig   = 1'b0;
      m_streak = 0;
      m_cnt    = 0;
    end else begin
      m_s = m_sync[SS-1];
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = btn_in;
      m_trig = 1'b0;
      if (m_s != m_level) begin
        m_streak++;
        if (m_streak == DB) begin
          m_level  = m_s;
          m_streak = 0;
          m_trig   = m_s ? mode[0] : mode[1];
        end
      end else begin
        m_streak = 0;
      end
      if (evt_clr) m_cnt = 0;
      else if (m_trig && m_cnt < CMAX) m_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; btn_in = 1'b0; mode = 2'b01; evt_clr = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if (level_out !== 1'b0) begin n_fail++; $display("FAIL reset_level got %b want 0", level_out); end
    n_checks++;
    if (trig_out !== 1'b0) begin n_fail++; $display("FAIL reset_trig got %b want 0", trig_out); end
    n_checks++;
    if (event_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", event_cnt); end
    rstn = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic test_clean_rise();
    int pulses = 0;
    mode = 2'b01;
    evt_clr = 1'b1; cyc(); evt_clr = 1'b0;
    btn_in = 1'b0;
    repeat (10) cyc();
    btn_in = 1'b1;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (trig_out === 1'b1) pulses++;
      n_checks++;
      if (trig_out !== (n == EDGE)) begin
        n_fail++; $display("FAIL rise_latency edge %0d trig got %b want %b", n, trig_out, (n == EDGE));
      end
      n_checks++;
      if (level_out !== (n >= EDGE)) begin
        n_fail++; $display("FAIL rise_level edge %0d got %b want %b", n, level_out, (n >= EDGE));
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL rise_pulses got %0d want 1", pulses); end
    n_checks++;
    if (event_cnt !== EW'(1)) begin n_fail++; $display("FAIL rise_cnt got %0d want 1", event_cnt); end
    btn_in = 1'b0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      n_checks++;
      if (trig_out !== 1'b0 || level_out !== (n < EDGE)) begin
        n_fail++; $display("FAIL fall_mode01 edge %0d trig %b level %b want trig 0 level %b", n, trig_out, level_out, (n < EDGE));
      end
    end
  endtask

  task automatic test_bounce();
    int pat_len[4] = '{5, 1, 15, 1};
    bit pat_val[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int pulses = 0;
    mode = 2'b01;
    for (int p = 0; p < 4; p++) begin
      btn_in = pat_val[p];
      for (int n = 0; n < pat_len[p]; n++) begin
        cyc();
        n_checks++;
        if (trig_out !== 1'b0 || level_out !== 1'b0) begin
          n_fail++; $display("FAIL bounce_reject seg %0d trig %b level %b want 0 0", p, trig_out, level_out);
        end
      end
    end
    btn_in = 1'b1;
    for (int n = 0; n < 20 + SS; n++) begin
      cyc();
      if (trig_out === 1'b1) pulses++;
      n_checks++;
      if (trig_out !== (n == EDGE)) begin
        n_fail++; $display("FAIL bounce_restart edge %0d trig got %b want %b", n, trig_out, (n == EDGE));
      end
    end
    n_checks++;
    if (pulses != 1 || level_out !== 1'b1) begin
      n_fail++; $display("FAIL bounce_final pulses %0d level %b want 1 1", pulses, level_out);
    end
    btn_in = 1'b0;
    repeat (25) cyc();
  endtask

  task automatic test_modes();
    int want[4] = '{0, 1, 1, 2};
    for (int m = 0; m < 4; m++) begin
      int pulses = 0;
      mode = 2'(m);
      for (int ph = 0; ph < 2; ph++) begin
        btn_in = (ph == 0);
        for (int n = 0; n < 25; n++) begin
          cyc();
          if (trig_out === 1'b1) pulses++;
          n_checks++;
          if (level_out !== m_level || trig_out !== m_trig) begin
            n_fail++; $display("FAIL mode%0d_track level %b/%b trig %b/%b", m, level_out, m_level, trig_out, m_trig);
          end
        end
        n_checks++;
        if (level_out !== (ph == 0)) begin
          n_fail++; $display("FAIL mode%0d_level phase %0d got %b want %b", m, ph, level_out, (ph == 0));
        end
      end
      n_checks++;
      if (pulses != want[m]) begin
        n_fail++; $display("FAIL mode%0d_pulses got %0d want %0d", m, pulses, want[m]);
      end
    end
  endtask

  task automatic test_counter();
    mode = 2'b11;
    btn_in = 1'b0;
    evt_clr = 1'b1; cyc(); evt_clr = 1'b0;
    n_checks++;
    if (event_cnt !== '0) begin n_fail++; $display("FAIL cnt_clear got %0d want 0", event_cnt); end
    for (int i = 1; i <= 9; i++) begin
      int want;
      btn_in = ~btn_in;
      repeat (22) cyc();
      want = (i > CMAX) ? CMAX : i;
      n_checks++;
      if (event_cnt !== EW'(want)) begin
        n_fail++; $display("FAIL cnt_sat trig %0d got %0d want %0d", i, event_cnt, want);
      end
    end
    btn_in = ~btn_in;
    for (int n = 0; n < 22; n++) begin
      evt_clr = (n == EDGE);
      cyc();
      if (n == EDGE) begin
        n_checks++;
        if (trig_out !== 1'b1 || event_cnt !== '0) begin
          n_fail++; $display("FAIL cnt_clr_vs_trig trig %b cnt %0d want 1 0", trig_out, event_cnt);
        end
      end
    end
    evt_clr = 1'b0;
    btn_in = ~btn_in;
    repeat (22) cyc();
    n_checks++;
    if (event_cnt !== EW'(1)) begin n_fail++; $display("FAIL cnt_after_clr got %0d want 1", event_cnt); end
  endtask

  task automatic test_reset_mid();
    mode = 2'b01;
    btn_in = 1'b0;
    repeat (25) cyc();
    btn_in = 1'b1;
    repeat (SS + 10) cyc();
    rstn = 1'b0;
    #1;
    n_checks++;
    if (level_out !== 1'b0 || trig_out !== 1'b0 || event_cnt !== '0) begin
      n_fail++; $display("FAIL reset_async level %b trig %b cnt %0d want 0 0 0", level_out, trig_out, event_cnt);
    end
    repeat (3) cyc();
    rstn = 1'b1;
    for (int n = 0; n < EDGE + 6; n++) begin
      cyc();
      n_checks++;
      if (trig_out !== (n == EDGE) || level_out !== (n >= EDGE)) begin
        n_fail++; $display("FAIL reset_release edge %0d trig %b level %b want %b %b", n, trig_out, level_out, (n == EDGE), (n >= EDGE));
      end
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int c = 0; c < 2500; c++) begin
      if (left == 0) begin
        left   = $urandom_range(1, 24);
        btn_in = $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      end
      left--;
      evt_clr = ($urandom_range(0, 15) == 0);
      rstn    = ($urandom_range(0, 299) != 0);
      cyc();
      n_checks++;
      if (level_out !== m_level || trig_out !== m_trig || event_cnt !== EW'(m_cnt)) begin
        n_fail++;
        $display("FAIL random cycle %0d level %b/%b trig %b/%b cnt %0d/%0d", c, level_out, m_level, trig_out, m_trig, event_cnt, m_cnt);
      end
    end
    rstn = 1'b1;
    evt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_modes();
    test_counter();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
